instr_feeder: RTL and testbench

- Instruction-stream producer for simple_processor_Top: the block that drives the processor's DIN and Run inputs.
- Holds a small program memory. On Start it issues each instruction word, plus the immediate word for mvi, and waits for the processor's Done before issuing the next.
- Sits beside simple_processor_Top in the top level and replaces hand-timed DIN stimulus.

---
 rtl/instr_feeder_if.sv | 44 ++++
 rtl/instr_feeder.sv | 202 ++++++++++++++++++++
 tb/tb_instr_feeder.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_feeder_if.sv
// ---------------------------------------------------------------------------
// instr_feeder_if
// Bundles every non-clock signal of the instruction feeder.
//
// Signals
//   load_en, load_addr, load_data : program memory write port (host side)
//   prog_len                      : number of words to issue, sampled on start
//   start                         : one-cycle pulse that launches the program
//   done                          : processor Done
//   din, run                      : word and strobe driven to the processor
//   busy, prog_done, error        : feeder status
//   issued                        : words issued so far in this program
//
// Modports
//   master : host/processor side (drives load, start and done)
//   slave  : the feeder itself
// ---------------------------------------------------------------------------
interface instr_feeder_if #(
  parameter int INSTR_W = 9,
  parameter int AW      = 4
);
  logic               load_en;
  logic [AW-1:0]      load_addr;
  logic [INSTR_W-1:0] load_data;
  logic [AW:0]        prog_len;
  logic               start;
  logic               done;
  logic [INSTR_W-1:0] din;
  logic               run;
  logic               busy;
  logic               prog_done;
  logic               error;
  logic [AW:0]        issued;

  modport master (
    output load_en, load_addr, load_data, prog_len, start, done,
    input  din, run, busy, prog_done, error, issued
  );

  modport slave (
    input  load_en, load_addr, load_data, prog_len, start, done,
    output din, run, busy, prog_done, error, issued
  );
endinterface

// File: rtl/instr_feeder.sv
// ---------------------------------------------------------------------------
// instr_feeder
// Instruction-stream producer for simple_processor_Top. Holds a small program
// memory and, on start, issues each instruction word (plus the immediate word
// of an mvi) to the processor, waiting for Done between instructions.
//
// Ports
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : instr_feeder_if.slave
//          in : load_en/load_addr/load_data, prog_len, start, done
//          out: din, run, busy, prog_done, error, issued
//
// Instruction format: opcode = word[2:0]; 3'b001 (mvi) is followed by one
// immediate word, every other opcode is a single word.
// ---------------------------------------------------------------------------
module instr_feeder #(
  parameter int INSTR_W = 9,
  parameter int AW      = 4,
  parameter int TIMEOUT = 64,
  parameter int TW      = 7
) (
  input  logic           clk,
  input  logic           rst,
  instr_feeder_if.slave  bus
);

  localparam int              DEPTH    = 2**AW;
  localparam logic [AW:0]     LEN_MAX  = (AW+1)'(DEPTH);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [2:0]      OP_MVI   = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_IMM,
    S_WAIT,
    S_FINISH,
    S_ERR
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [AW:0]        pc;
  logic [AW:0]        len_r;
  logic [AW:0]        issued_r;
  logic [AW:0]        len_in;
  logic [TW-1:0]      tcnt;
  logic [INSTR_W-1:0] din_r;
  logic [INSTR_W-1:0] cur_word;
  logic               error_r;
  logic               start_ok;

  function automatic logic is_mvi(input logic [INSTR_W-1:0] w);
    return (w[2:0] == OP_MVI);
  endfunction

  // An mvi whose immediate would fall at or beyond the program end is a
  // malformed program. This is decided before the instruction is issued so
  // that the processor never sees a half instruction.
  function automatic logic missing_imm(input logic [INSTR_W-1:0] w,
                                       input logic [AW:0]      p,
                                       input logic [AW:0]      l);
    return is_mvi(w) && (({1'b0, p} + 1'b1) >= {1'b0, l});
  endfunction

  function automatic logic [AW:0] clamp_len(input logic [AW:0] l);
    return (l > LEN_MAX) ? LEN_MAX : l;
  endfunction

  assign len_in   = clamp_len(bus.prog_len);
  // pc can equal DEPTH only after the last word, when the read is unused.
  assign cur_word = mem[pc[AW-1:0]];
  assign start_ok = (state == S_IDLE) && bus.start;

  // Program memory: written only while idle, never reset.
  always_ff @(posedge clk) begin
    if (bus.load_en && (state == S_IDLE)) begin
      mem[bus.load_addr] <= bus.load_data;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and outputs
  always_comb begin
    state_nxt     = state;
    bus.run       = 1'b0;
    bus.din       = din_r;
    bus.busy      = (state != S_IDLE);
    bus.prog_done = 1'b0;
    bus.error     = error_r;
    bus.issued    = issued_r;

    case (state)
      S_IDLE: begin
        if (bus.start) begin
          if (len_in == '0) begin
            state_nxt = S_FINISH;
          end else if (missing_imm(mem[0], '0, len_in)) begin
            state_nxt = S_ERR;
          end else begin
            state_nxt = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        bus.run   = 1'b1;
        bus.din   = cur_word;
        state_nxt = is_mvi(cur_word) ? S_IMM : S_WAIT;
      end

      S_IMM: begin
        bus.din   = cur_word;
        state_nxt = S_WAIT;
      end

      S_WAIT: begin
        if (bus.done) begin
          if (pc >= len_r) begin
            state_nxt = S_FINISH;
          end else if (missing_imm(cur_word, pc, len_r)) begin
            state_nxt = S_ERR;
          end else begin
            state_nxt = S_ISSUE;
          end
        end else if (tcnt == TMO_LAST) begin
          state_nxt = S_ERR;
        end
      end

      S_FINISH: begin
        bus.prog_done = 1'b1;
        state_nxt     = S_IDLE;
      end

      S_ERR: begin
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Program counter, issue count, timeout counter, held DIN and error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= '0;
      len_r    <= '0;
      issued_r <= '0;
      tcnt     <= '0;
      din_r    <= '0;
      error_r  <= 1'b0;
    end else begin
      // Setting wins over clearing so that a start which immediately fails
      // still leaves the flag raised.
      if (state_nxt == S_ERR) begin
        error_r <= 1'b1;
      end else if (start_ok) begin
        error_r <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (bus.start) begin
            len_r    <= len_in;
            pc       <= '0;
            issued_r <= '0;
            tcnt     <= '0;
          end
        end

        S_ISSUE, S_IMM: begin
          din_r    <= cur_word;
          pc       <= pc + 1'b1;
          issued_r <= issued_r + 1'b1;
          tcnt     <= '0;
        end

        S_WAIT: begin
          tcnt <= bus.done ? '0 : (tcnt + 1'b1);
        end

        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_feeder.sv
// ---------------------------------------------------------------------------
// tb_instr_feeder
// Self-checking bench for instr_feeder. Stimulus pushes the expected word
// stream and program outcome into queues; a monitor pops and compares as the
// DUT presents run pulses and program completions. A processor stand-in
// answers each issued instruction with Done after a random delay.
// ---------------------------------------------------------------------------
module tb_instr_feeder;
  localparam int INSTR_W = 9;
  localparam int AW      = 4;
  localparam int TIMEOUT = 64;
  localparam int TW      = 7;
  localparam int DEPTH   = 16;

  logic clk = 1'b0;
  logic rst;

  instr_feeder_if #(.INSTR_W(INSTR_W), .AW(AW)) bus ();

  instr_feeder #(.INSTR_W(INSTR_W), .AW(AW), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] word;
    bit         has_imm;
    logic [8:0] imm;
  } wexp_t;

  typedef struct {
    bit err;
    bit tmo;
    int issued;
  } oexp_t;

  wexp_t      wq[$];
  oexp_t      oq[$];
  logic [8:0] mm [DEPTH];
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  int         stall_at = -1;
  int         resp_idx = 0;
  int         start_cyc = 0;
  bit         first_run = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Walks the program as the processor would see it.
  task automatic build_expect(input int len, input int stall, output oexp_t o);
    int l;
    int p;
    int k;
    logic [8:0] w;
    l = (len > DEPTH) ? DEPTH : len;
    p = 0;
    k = 0;
    o.err = 1'b0;
    o.tmo = 1'b0;
    while (p < l) begin
      w = mm[p];
      if (w[2:0] == 3'b001) begin
        if (p + 1 >= l) begin
          o.err = 1'b1;
          break;
        end
        wq.push_back('{w, 1'b1, mm[p+1]});
        p += 2;
      end else begin
        wq.push_back('{w, 1'b0, 9'd0});
        p += 1;
      end
      if (k == stall) begin
        o.err = 1'b1;
        o.tmo = 1'b1;
        break;
      end
      k++;
    end
    o.issued = p;
    oq.push_back(o);
  endtask

  task automatic load(input int a, input logic [8:0] d);
    @(posedge clk); #1;
    bus.load_en   = 1'b1;
    bus.load_addr = 4'(a);
    bus.load_data = d;
    @(posedge clk); #1;
    bus.load_en   = 1'b0;
    mm[a] = d;
  endtask

  task automatic launch(input int len, input int stall, output oexp_t o);
    build_expect(len, stall, o);
    stall_at  = stall;
    resp_idx  = 0;
    first_run = 1'b1;
    @(posedge clk); #1;
    bus.prog_len = 5'(len);
    bus.start    = 1'b1;
    start_cyc    = cyc;
    @(posedge clk); #1;
    bus.start    = 1'b0;
  endtask

  task automatic run_prog(input int len, input int stall, output int bcycles);
    oexp_t o;
    int n;
    launch(len, stall, o);
    @(negedge clk);
    if (!(o.err && !o.tmo && o.issued == 0)) chk("error_cleared_by_start", bus.error, 0);
    n = 0;
    bcycles = 0;
    while (bus.busy && n < 3000) begin
      bcycles++;
      n++;
      @(negedge clk);
    end
    chk("busy_bound", n < 3000, 1);
    repeat (3) @(negedge clk);
  endtask

  // Processor stand-in: sometimes raises Done during ISSUE/IMM (must be
  // ignored), then answers with a real Done a random number of cycles later.
  initial begin
    int  idx;
    int  d;
    bit  is_m;
    bus.done = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.done = 1'b0;
      if (!rst && bus.run) begin
        is_m = (bus.din[2:0] == 3'b001);
        idx  = resp_idx;
        resp_idx++;
        bus.done = ($urandom_range(0, 3) == 0);
        @(posedge clk); #1;
        bus.done = 1'b0;
        if (is_m) begin
          bus.done = ($urandom_range(0, 3) == 0);
          @(posedge clk); #1;
          bus.done = 1'b0;
        end
        d = $urandom_range(1, 6);
        repeat (d - 1) begin
          @(posedge clk); #1;
        end
        if (idx != stall_at) bus.done = 1'b1;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    bit         pend;
    logic [8:0] imm_e;
    bit         prev_run;
    bit         prev_done;
    bit         prev_busy;
    int         seen_done;
    int         last_word;
    wexp_t      e;
    oexp_t      o;
    pend = 0; prev_run = 0; prev_done = 0; prev_busy = 0; seen_done = 0; last_word = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend      = 0;
        seen_done = 0;
      end else begin
        if (bus.run) chk("run_not_consecutive", prev_run, 0);
        if (pend) begin
          chk("imm_run_low", bus.run, 0);
          chk("imm_din", bus.din, imm_e);
          pend      = 0;
          last_word = cyc;
        end else if (bus.run) begin
          chk("run_expected", wq.size() > 0, 1);
          if (wq.size() > 0) begin
            e = wq.pop_front();
            chk("instr_din", bus.din, e.word);
            if (first_run) chk("start_to_run", cyc, start_cyc + 1);
            else           chk("done_to_run", prev_done, 1);
            first_run = 1'b0;
            last_word = cyc;
            if (e.has_imm) begin
              pend  = 1;
              imm_e = e.imm;
            end
          end
        end
        if (bus.prog_done) begin
          seen_done++;
          if (oq.size() > 0 && oq[0].issued > 0) chk("done_to_prog_done", prev_done, 1);
        end
        if (prev_busy && !bus.busy) begin
          chk("outcome_expected", oq.size() > 0, 1);
          if (oq.size() > 0) begin
            o = oq.pop_front();
            chk("end_error", bus.error, o.err);
            chk("prog_done_count", seen_done, o.err ? 0 : 1);
            chk("issued", bus.issued, o.issued);
            chk("words_consumed", wq.size() + pend, 0);
            if (o.tmo) chk("timeout_cycles", cyc - last_word, TIMEOUT + 2);
          end
          seen_done = 0;
        end
      end
      prev_run  = bus.run;
      prev_done = bus.done;
      prev_busy = bus.busy;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int    bc;
    oexp_t o;
    rst           = 1'b1;
    bus.load_en   = 1'b0;
    bus.load_addr = '0;
    bus.load_data = '0;
    bus.prog_len  = '0;
    bus.start     = 1'b0;
    @(negedge clk);
    chk("rst_din", bus.din, 0);
    chk("rst_run", bus.run, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_prog_done", bus.prog_done, 0);
    chk("rst_error", bus.error, 0);
    chk("rst_issued", bus.issued, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) load(i, 9'd0);

    // mvi followed by its immediate
    load(0, 9'b111_000_001);
    load(1, 9'b111_001_111);
    run_prog(2, -1, bc);

    // mv, then mvi + immediate
    load(0, 9'b000_101_010);
    load(1, 9'b111_010_001);
    load(2, 9'b111_111_111);
    run_prog(3, -1, bc);

    // empty program
    run_prog(0, -1, bc);
    chk("len0_busy_cycles", bc, 1);

    // mvi as the only word: missing immediate
    load(0, 9'b111_000_001);
    run_prog(1, -1, bc);
    chk("missing_imm_busy_cycles", bc, 1);

    // Done withheld: timeout, then a fresh start clears the error
    load(0, 9'b000_101_010);
    run_prog(1, 0, bc);
    run_prog(3, -1, bc);

    // Reset during WAIT, with load and start attempts while busy
    load(0, 9'b000_000_010);
    launch(1, 0, o);
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    bus.load_en   = 1'b1;
    bus.load_addr = 4'd0;
    bus.load_data = 9'h1AA;
    bus.start     = 1'b1;
    bus.prog_len  = 5'd3;
    @(posedge clk); #1;
    bus.load_en = 1'b0;
    bus.start   = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("async_rst_din", bus.din, 0);
    chk("async_rst_run", bus.run, 0);
    chk("async_rst_busy", bus.busy, 0);
    chk("async_rst_prog_done", bus.prog_done, 0);
    chk("async_rst_error", bus.error, 0);
    chk("async_rst_issued", bus.issued, 0);
    wq.delete();
    oq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    run_prog(1, -1, bc);

    // Randomized programs
    for (int t = 0; t < 14; t++) begin
      int len;
      int st;
      logic [8:0] w;
      for (int a = 0; a < DEPTH; a++) begin
        if ($urandom_range(0, 1) == 1) begin
          w = 9'($urandom);
          if ($urandom_range(0, 2) == 0) w[2:0] = 3'b001;
          else if (w[2:0] == 3'b001) w[2:0] = 3'b010;
          load(a, w);
        end
      end
      len = $urandom_range(0, 31);
      st  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 3) : -1;
      run_prog(len, st, bc);
    end

    chk("final_words_empty", wq.size(), 0);
    chk("final_outcomes_empty", oq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
